// File: rtl/pipe_stage_reg_if.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg_if
//   Beat channel between two pipeline stages: a data bundle and a control
//   bundle qualified by a valid/ready handshake.
//
//   Handshake: a beat moves across the channel on a rising clock edge where
//   valid and ready are both high. The master keeps valid, data and ctrl
//   stable until that happens. Ready may be high while valid is low.
//
//   Signals
//     valid  master -> slave  beat present
//     ready  slave -> master  slave accepts a beat this cycle
//     data   master -> slave  DATA_W-bit data bundle
//     ctrl   master -> slave  CTRL_W-bit control bundle
//
//   Modports
//     master  drives valid/data/ctrl, samples ready
//     slave   samples valid/data/ctrl, drives ready
// -----------------------------------------------------------------------------
interface pipe_stage_reg_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 14
);
   logic              valid;
   logic              ready;
   logic [DATA_W-1:0] data;
   logic [CTRL_W-1:0] ctrl;

   modport master (output valid, output data, output ctrl, input ready);
   modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Flow-controlled pipeline stage register. One instance sits between each
//   pair of pipeline stages and carries a data bundle plus a control bundle.
//   Supports stall (hold contents) and flush (drop contents, insert bubble),
//   and keeps saturating transfer/flush counters for performance debug.
//
//   Priority: reset > flush > stall > normal operation.
//
//   Build option
//     PIPE_STAGE_SKID_EN  when defined, a one-entry skid register is added so
//                         the stage holds up to two beats and up.ready comes
//                         from a register (no combinational path from
//                         dn.ready). When undefined, the stage holds one
//                         beat and up.ready depends on dn.ready.
//
//   Parameters
//     DATA_W       width of the data bundle
//     CTRL_W       width of the control bundle
//     BUBBLE_CTRL  control value presented while no valid beat is held
//     CNT_W        width of each performance counter
//
//   Ports
//     clk        in   rising-edge clock for all state
//     reset      in   asynchronous, active-low reset
//     up         slave modport: in_valid/in_ready/in_data/in_ctrl
//     dn         master modport: out_valid/out_ready/out_data/out_ctrl
//     stall      in   hold stage contents, block both handshakes
//     flush      in   discard contents (and any offered beat), insert bubble
//     xfer_cnt   out  saturating count of output transfers
//     flush_cnt  out  saturating count of flush cycles
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned       DATA_W      = 32,
   parameter int unsigned       CTRL_W      = 14,
   parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
   parameter int unsigned       CNT_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   pipe_stage_reg_if.slave      up,
   pipe_stage_reg_if.master     dn,
   input  logic                 stall,
   input  logic                 flush,
   output logic [CNT_W-1:0]     xfer_cnt,
   output logic [CNT_W-1:0]     flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Main register: the beat currently presented downstream.
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;

   logic [CNT_W-1:0]  xfer_cnt_d, flush_cnt_d;

   logic in_ready;
   logic out_valid;
   logic in_fire;
   logic out_fire;

   // A held beat is hidden from downstream while stalled, so nothing can
   // leave the stage during a stall.
   assign out_valid = valid_q & ~stall;
   assign out_fire  = out_valid & dn.ready;
   // A beat offered during flush is dropped even if the stage looks ready.
   assign in_fire   = up.valid & in_ready & ~flush;

   assign up.ready  = in_ready;
   assign dn.valid  = out_valid;
   assign dn.data   = data_q;
   assign dn.ctrl   = ctrl_q;

`ifdef PIPE_STAGE_SKID_EN
   // Skid register: catches a beat accepted while the main register is
   // occupied and cannot drain. Ready only depends on skid occupancy, which
   // breaks the dn.ready -> up.ready path.
   logic              skid_valid_q, skid_valid_d;
   logic [DATA_W-1:0] skid_data_q,  skid_data_d;
   logic [CTRL_W-1:0] skid_ctrl_q,  skid_ctrl_d;

   assign in_ready = ~skid_valid_q & ~stall;

   always_comb begin
      valid_d      = valid_q;
      data_d       = data_q;
      ctrl_d       = ctrl_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      skid_ctrl_d  = skid_ctrl_q;

      if (flush) begin
         valid_d      = 1'b0;
         data_d       = '0;
         ctrl_d       = BUBBLE_CTRL;
         skid_valid_d = 1'b0;
         skid_data_d  = '0;
         skid_ctrl_d  = BUBBLE_CTRL;
      end else if (!stall) begin
         if (out_fire) begin
            if (skid_valid_q) begin
               // Older beat waiting in the skid moves up. in_fire cannot be
               // set here because the full skid drops in_ready.
               valid_d      = 1'b1;
               data_d       = skid_data_q;
               ctrl_d       = skid_ctrl_q;
               skid_valid_d = 1'b0;
            end else if (in_fire) begin
               valid_d = 1'b1;
               data_d  = up.data;
               ctrl_d  = up.ctrl;
            end else begin
               // Drained: present a bubble, keep the stale data bundle.
               valid_d = 1'b0;
               ctrl_d  = BUBBLE_CTRL;
            end
         end else if (in_fire) begin
            if (!valid_q) begin
               valid_d = 1'b1;
               data_d  = up.data;
               ctrl_d  = up.ctrl;
            end else begin
               skid_valid_d = 1'b1;
               skid_data_d  = up.data;
               skid_ctrl_d  = up.ctrl;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_ctrl_q  <= BUBBLE_CTRL;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
         skid_ctrl_q  <= skid_ctrl_d;
      end
   end
`else
   // Single-entry stage: accept when empty or when the held beat leaves on
   // this same edge.
   assign in_ready = (~valid_q | dn.ready) & ~stall;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      ctrl_d  = ctrl_q;

      if (flush) begin
         valid_d = 1'b0;
         data_d  = '0;
         ctrl_d  = BUBBLE_CTRL;
      end else if (!stall) begin
         if (in_fire) begin
            valid_d = 1'b1;
            data_d  = up.data;
            ctrl_d  = up.ctrl;
         end else if (out_fire) begin
            // Drained: present a bubble, keep the stale data bundle.
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_CTRL;
         end
      end
   end
`endif

   // Performance counters stick at their maximum instead of wrapping.
   // A transfer that completes in a flush cycle was seen downstream, so it
   // is still counted.
   always_comb begin
      xfer_cnt_d  = xfer_cnt;
      flush_cnt_d = flush_cnt;
      if (out_fire && (xfer_cnt != CNT_MAX)) begin
         xfer_cnt_d = xfer_cnt + CNT_W'(1);
      end
      if (flush && (flush_cnt != CNT_MAX)) begin
         flush_cnt_d = flush_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= 1'b0;
         data_q    <= '0;
         ctrl_q    <= BUBBLE_CTRL;
         xfer_cnt  <= '0;
         flush_cnt <= '0;
      end else begin
         valid_q   <= valid_d;
         data_q    <= data_d;
         ctrl_q    <= ctrl_d;
         xfer_cnt  <= xfer_cnt_d;
         flush_cnt <= flush_cnt_d;
      end
   end

endmodule
